// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255-style PPI Port A Mode 1 input path.
//   ppi_state_e  : handshake state of the strobed-input engine
//   PC_*_A       : Port C bit positions used by Port A in Mode 1
//   BSR_*        : field positions inside a bit-set/reset control word
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2,
    READ    = 2'd3
  } ppi_state_e;

  localparam int unsigned PC_INTR_A = 3;
  localparam int unsigned PC_INTE_A = 4;
  localparam int unsigned PC_IBF_A  = 5;

  localparam int unsigned BSR_SEL_BIT = 7;
  localparam int unsigned BSR_IDX_MSB = 3;
  localparam int unsigned BSR_IDX_LSB = 1;
  localparam int unsigned BSR_VAL_BIT = 0;

endpackage

// File: rtl/ppi_edge_sync.sv
// N-stage synchronizer followed by a rise/fall edge detector.
//   clk, rst_n : clock, async active-low reset (flops reset to 1 = idle line)
//   d_i        : asynchronous (or synchronous) input level
//   rise_o_c   : one-cycle combinational pulse, synchronized level went 0->1
//   fall_o_c   : one-cycle combinational pulse, synchronized level went 1->0
module ppi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o_c,
  output logic fall_o_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one extra flop holding the previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o_c = ~prev_q &  sync_q[STAGES-1];
  assign fall_o_c =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ppi_mode1_input_port.sv
// 8255-style Port A Mode 1 (strobed input) handshake engine.
// Latches PA_IN on the peripheral strobe, raises IBF/INTR, and releases the
// buffer once the CPU read completes. INTE is controlled by BSR writes.
// Optional feature macro: PPI_OVERRUN_FLAG_EN adds a sticky OVERRUN output.
// Ports:
//   CLK, RESET_N  : clock, asynchronous active-low reset
//   ENABLE        : Port A configured for Mode 1 input
//   PA_IN         : peripheral data bus
//   STB_N         : peripheral strobe, active-low, asynchronous
//   RD_N          : CPU read of Port A, active-low, synchronous
//   BSR_WR        : control word write pulse
//   BSR_CONTROL   : control word (BSR when bit7=0)
//   DATA_OUT      : latched Port A data
//   IBF, INTR     : Port C status lines (bits 5 and 3)
//   INTE          : interrupt enable readback
//   OVERRUN       : sticky overrun flag (only with PPI_OVERRUN_FLAG_EN)
module ppi_mode1_input_port
  import ppi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INTE_BIT    = PC_INTE_A
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] PA_IN,
  input  logic                  STB_N,
  input  logic                  RD_N,
  input  logic                  BSR_WR,
  input  logic [7:0]            BSR_CONTROL,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  IBF,
  output logic                  INTR,
  output logic                  INTE
`ifdef PPI_OVERRUN_FLAG_EN
  ,
  output logic                  OVERRUN
`endif
);

  logic stb_rise_c, stb_fall_c;
  logic rd_rise_c,  rd_fall_c;
  logic bsr_hit_c;
  logic unused_bsr_bits;

  ppi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  ibf_q,   ibf_d;
  logic                  intr_q,  intr_d;
  logic                  inte_q,  inte_d;
  logic [DATA_WIDTH-1:0] pa_pipe_q [SYNC_STAGES];

  // Strobe goes through the full synchronizer depth
  ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .d_i      (STB_N),
    .rise_o_c (stb_rise_c),
    .fall_o_c (stb_fall_c)
  );

  // RD_N is already synchronous, one register is enough for edge detection
  ppi_edge_sync #(.STAGES(1)) u_rd_sync (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .d_i      (RD_N),
    .rise_o_c (rd_rise_c),
    .fall_o_c (rd_fall_c)
  );

  // Data delay line matching the strobe synchronizer so the captured word is the one present at the strobe fall
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        pa_pipe_q[i] <= '0;
      end
    end else begin
      pa_pipe_q[0] <= PA_IN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        pa_pipe_q[i] <= pa_pipe_q[i-1];
      end
    end
  end

  assign bsr_hit_c = BSR_WR && !BSR_CONTROL[BSR_SEL_BIT] &&
                     (BSR_CONTROL[BSR_IDX_MSB:BSR_IDX_LSB] == 3'(INTE_BIT));
  assign unused_bsr_bits = ^BSR_CONTROL[6:4];

  // State register and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      data_q  <= '0;
      ibf_q   <= 1'b0;
      intr_q  <= 1'b0;
      inte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ibf_q   <= ibf_d;
      intr_q  <= intr_d;
      inte_q  <= inte_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    inte_d  = inte_q;

    // INTE follows BSR writes regardless of ENABLE or handshake state
    if (bsr_hit_c) begin
      inte_d = BSR_CONTROL[BSR_VAL_BIT];
    end

    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (stb_fall_c) begin
            data_d  = pa_pipe_q[SYNC_STAGES-1];
            state_d = CAPTURE;
          end
        end
        CAPTURE: if (stb_rise_c) state_d = FULL;
        FULL:    if (rd_fall_c)  state_d = READ;
        READ:    if (rd_rise_c)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ibf_d  = (state_d != IDLE);
    intr_d = inte_q && (state_d == FULL);
  end

  assign DATA_OUT = data_q;
  assign IBF      = ibf_q;
  assign INTR     = intr_q;
  assign INTE     = inte_q;

`ifdef PPI_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a new strobe while the buffer is busy wins over the clear on read completion
  always_comb begin
    overrun_d = overrun_q;
    if (!ENABLE) begin
      overrun_d = 1'b0;
    end else if (stb_fall_c && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if ((state_q == READ) && rd_rise_c) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign OVERRUN = overrun_q;
`endif

endmodule

// File: tb/tb_ppi_mode1_input_port.sv
// Self-checking bench for ppi_mode1_input_port: directed handshake scenarios
// followed by randomized pin activity, all checked every cycle against a
// behavioural model built from pin-sample history and handshake flags.
module tb_ppi_mode1_input_port;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 2;
  localparam int unsigned IB = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] pa_in;
  logic          stb_n;
  logic          rd_n;
  logic          bsr_wr;
  logic [7:0]    bsr_ctrl;
  logic [DW-1:0] data_out;
  logic          ibf;
  logic          intr;
  logic          inte;
`ifdef PPI_OVERRUN_FLAG_EN
  logic          overrun;
`endif

  ppi_mode1_input_port #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (NS),
    .INTE_BIT    (IB)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .ENABLE      (enable),
    .PA_IN       (pa_in),
    .STB_N       (stb_n),
    .RD_N        (rd_n),
    .BSR_WR      (bsr_wr),
    .BSR_CONTROL (bsr_ctrl),
    .DATA_OUT    (data_out),
    .IBF         (ibf),
    .INTR        (intr),
    .INTE        (inte)
`ifdef PPI_OVERRUN_FLAG_EN
    ,
    .OVERRUN     (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history (index 0 = value seen at the current edge)
  logic [NS+1:0] stb_h;
  logic [2:0]    rd_h;
  logic [DW-1:0] pa_h [NS+1];
  logic [DW-1:0] m_data;
  logic          m_inte, m_intr, m_full, m_released, m_reading, m_ovr;

  task automatic model_reset();
    stb_h = '1;
    rd_h  = '1;
    for (int i = 0; i <= int'(NS); i++) pa_h[i] = '0;
    m_data = '0; m_inte = 0; m_intr = 0;
    m_full = 0; m_released = 0; m_reading = 0; m_ovr = 0;
  endtask

  // Strobe edges become visible NS samples late, read edges one sample late
  task automatic model_edge();
    logic sf, sr, rf, rr, full0, reading0, inte0;
    sf = stb_h[NS+1] & ~stb_h[NS];
    sr = ~stb_h[NS+1] & stb_h[NS];
    rf = rd_h[2] & ~rd_h[1];
    rr = ~rd_h[2] & rd_h[1];
    full0 = m_full; reading0 = m_reading; inte0 = m_inte;
    if (bsr_wr && !bsr_ctrl[7] && (bsr_ctrl[3:1] == 3'(IB))) m_inte = bsr_ctrl[0];
    if (!enable) begin
      m_full = 0; m_released = 0; m_reading = 0; m_ovr = 0;
    end else begin
      if (!m_full) begin
        if (sf) begin
          m_data = pa_h[NS]; m_full = 1; m_released = 0; m_reading = 0;
        end
      end else if (!m_released) begin
        if (sr) m_released = 1;
      end else if (!m_reading) begin
        if (rf) m_reading = 1;
      end else if (rr) begin
        m_full = 0;
      end
      if (full0 && sf) m_ovr = 1;
      else if (reading0 && rr) m_ovr = 0;
    end
    m_intr = inte0 && m_full && m_released && !m_reading;
  endtask

  // One clock: record applied inputs, advance model, compare all outputs
  task automatic step();
    stb_h = {stb_h[NS:0], stb_n};
    rd_h  = {rd_h[1:0], rd_n};
    for (int i = int'(NS); i > 0; i--) pa_h[i] = pa_h[i-1];
    pa_h[0] = pa_in;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("ibf", 32'(ibf), 32'(m_full));
    check_eq("intr", 32'(intr), 32'(m_intr));
    check_eq("inte", 32'(inte), 32'(m_inte));
`ifdef PPI_OVERRUN_FLAG_EN
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
`endif
  endtask

  task automatic bsr(input logic [7:0] w);
    bsr_wr = 1'b1; bsr_ctrl = w;
    step();
    bsr_wr = 1'b0; bsr_ctrl = 8'h00;
    step();
  endtask

  task automatic strobe(input logic [DW-1:0] v, input int low);
    pa_in = v; stb_n = 1'b0;
    repeat (low) step();
    stb_n = 1'b1;
    repeat (NS + 2) step();
  endtask

  task automatic cpu_read();
    rd_n = 1'b0;
    repeat (3) step();
    rd_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; pa_in = '0; stb_n = 1'b1; rd_n = 1'b1;
    bsr_wr = 1'b0; bsr_ctrl = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_ibf", 32'(ibf), 32'h0);
    check_eq("rst_intr", 32'(intr), 32'h0);
    check_eq("rst_inte", 32'(inte), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // Basic handshake with latency checks
    bsr(8'h09);
    check_eq("bsr_inte_set", 32'(inte), 32'h1);
    pa_in = 8'hA5; stb_n = 1'b0;
    step(); step();
    check_eq("ibf_before", 32'(ibf), 32'h0);
    step();
    check_eq("ibf_lat", 32'(ibf), 32'h1);
    check_eq("data_a5", 32'(data_out), 32'hA5);
    step();
    stb_n = 1'b1;
    step(); step();
    check_eq("intr_before", 32'(intr), 32'h0);
    step();
    check_eq("intr_lat", 32'(intr), 32'h1);
    step();
    rd_n = 1'b0;
    step();
    check_eq("intr_hold", 32'(intr), 32'h1);
    step();
    check_eq("intr_drop", 32'(intr), 32'h0);
    step();
    rd_n = 1'b1;
    step();
    check_eq("ibf_hold", 32'(ibf), 32'h1);
    step();
    check_eq("ibf_clear", 32'(ibf), 32'h0);
    repeat (2) step();

    // INTE disabled: buffer fills without interrupt, then INTE re-enabled in FULL
    bsr(8'h08);
    strobe(8'h3C, 4);
    repeat (2) step();
    check_eq("noint_ibf", 32'(ibf), 32'h1);
    check_eq("noint_data", 32'(data_out), 32'h3C);
    check_eq("noint_intr", 32'(intr), 32'h0);
    bsr_wr = 1'b1; bsr_ctrl = 8'h09;
    step();
    bsr_wr = 1'b0; bsr_ctrl = 8'h00;
    check_eq("reen_inte", 32'(inte), 32'h1);
    step();
    check_eq("reen_intr", 32'(intr), 32'h1);
    cpu_read();

    // BSR filtering: mode-set word and another bit index leave INTE alone
    bsr(8'h08);
    bsr(8'h89);
    check_eq("filt_mode", 32'(inte), 32'h0);
    bsr(8'h0B);
    check_eq("filt_idx", 32'(inte), 32'h0);

    // Overrun while FULL
    bsr(8'h09);
    strobe(8'h11, 4);
    strobe(8'h22, 4);
    check_eq("ovr_data", 32'(data_out), 32'h11);
    check_eq("ovr_ibf", 32'(ibf), 32'h1);
    check_eq("ovr_intr", 32'(intr), 32'h1);
`ifdef PPI_OVERRUN_FLAG_EN
    check_eq("ovr_flag", 32'(overrun), 32'h1);
`endif
    cpu_read();
    check_eq("ovr_rd_data", 32'(data_out), 32'h11);
    check_eq("ovr_rd_ibf", 32'(ibf), 32'h0);
`ifdef PPI_OVERRUN_FLAG_EN
    check_eq("ovr_flag_clr", 32'(overrun), 32'h0);
`endif

    // ENABLE drop in FULL, strobe ignored while disabled
    strobe(8'h55, 4);
    enable = 1'b0;
    step();
    check_eq("dis_ibf", 32'(ibf), 32'h0);
    check_eq("dis_intr", 32'(intr), 32'h0);
    check_eq("dis_data", 32'(data_out), 32'h55);
    check_eq("dis_inte", 32'(inte), 32'h1);
    strobe(8'h66, 4);
    check_eq("dis_strobe_data", 32'(data_out), 32'h55);
    check_eq("dis_strobe_ibf", 32'(ibf), 32'h0);
    enable = 1'b1;
    repeat (4) step();

    // Reset in the middle of CAPTURE clears everything without a clock edge
    pa_in = 8'h77; stb_n = 1'b0;
    repeat (NS + 1) step();
    check_eq("cap_ibf", 32'(ibf), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", 32'(data_out), 32'h0);
    check_eq("mid_rst_ibf", 32'(ibf), 32'h0);
    check_eq("mid_rst_intr", 32'(intr), 32'h0);
    check_eq("mid_rst_inte", 32'(inte), 32'h0);
    stb_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) step();

    // Randomized pin activity
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) stb_n = ~stb_n;
      if ($urandom_range(0, 5) == 0) rd_n = ~rd_n;
      pa_in  = DW'($urandom);
      bsr_wr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) bsr_ctrl = {4'b0000, 3'(IB), 1'($urandom)};
      else                           bsr_ctrl = 8'($urandom);
      step();
    end
    enable = 1'b1; bsr_wr = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppi_mode1_input_port.md
Name: ppi_mode1_input_port

Overview:
- Mode 1 (strobed input) handshake engine for 8255-style PPI Port A.
- Sits on the opposite side of Port C from the BSR writer: that path sets or resets Port C bits; this block consumes the INTE bit written through BSR.
- Drives the Port C status lines IBF and INTR back to the peripheral and the CPU.
- Latches peripheral data on STB_N and holds it until the CPU read completes.

Parameters:
- DATA_WIDTH, 8, width of Port A data.
- SYNC_STAGES, 2, flip-flop stages in the STB_N synchronizer (minimum 2).
- INTE_BIT, 4, Port C bit index (0-7) whose BSR set/reset controls INTE.

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENABLE  input  1  high = Port A configured for Mode 1 input.
- PA_IN  input  DATA_WIDTH  peripheral data bus.
- STB_N  input  1  peripheral strobe, active-low, asynchronous to CLK.
- RD_N  input  1  CPU read of Port A, active-low, synchronous to CLK.
- BSR_WR  input  1  one-cycle pulse: a control word is written.
- BSR_CONTROL  input  8  control word; bit7=0 selects BSR, bits[3:1] select the Port C bit, bit0 = set(1)/reset(0).
- DATA_OUT  output  DATA_WIDTH  latched Port A data.
- IBF  output  1  input buffer full (Port C bit 5).
- INTR  output  1  interrupt request (Port C bit 3).
- INTE  output  1  interrupt enable status readback.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - DATA_OUT=0, IBF=0, INTR=0, INTE=0.
  - State=IDLE; synchronizer flops set to 1 (strobe idle).
- STB_N passes through SYNC_STAGES flops, then a rising/falling edge detector.
- PA_IN is sampled through the same number of stages so data stays aligned with the strobe.
- RD_N passes through a single register plus edge detector.
- States, registered, transitions only while ENABLE=1:
  - IDLE: on STB fall, latch PA_IN into DATA_OUT, set IBF, go to CAPTURE.
  - CAPTURE: on STB rise, go to FULL.
  - FULL: on RD fall, go to READ.
  - READ: on RD rise, clear IBF, go to IDLE.
- INTR is registered: INTR <= INTE && (state_next == FULL).
  - INTR therefore drops in the cycle after the RD fall is detected.
  - INTR rises in the cycle after the STB rise is detected, provided INTE=1.
- Latency:
  - STB_N fall at the pin to IBF=1: SYNC_STAGES+1 cycles.
  - RD_N fall to INTR=0: 2 cycles.
  - RD_N rise to IBF=0: 2 cycles.
- INTE update:
  - Condition: BSR_WR=1 && BSR_CONTROL[7]==0 && BSR_CONTROL[3:1]==INTE_BIT.
  - Effect: INTE <= BSR_CONTROL[0] on the next clock.
  - INTE is updated in any state and regardless of ENABLE.
  - Mode-set words (bit7=1) and other bit indices are ignored.
- INTE cleared while in FULL: INTR=0 one cycle later; data and IBF are kept. INTE set again while in FULL: INTR reasserts.
- Overrun (STB fall while in CAPTURE, FULL or READ): new data is discarded; DATA_OUT and state are unchanged.
- Simultaneous RD rise and STB fall in READ: READ goes to IDLE, and the strobe is treated as overrun and dropped. Peripherals must wait for IBF=0 before strobing.
- ENABLE=0:
  - State forced to IDLE; IBF=0, INTR=0.
  - DATA_OUT holds its last value; INTE is retained.
- Reset mid-handshake: immediate return to the reset values above, with no partial latch.

Optional Feature:
- Macro: PPI_OVERRUN_FLAG_EN.
- Defined:
  - Adds output OVERRUN (1 bit, reset 0).
  - OVERRUN is set sticky on any overrun strobe.
  - OVERRUN is cleared on the RD rise that completes the read, or when ENABLE=0.
- Undefined: the port is absent and overrun strobes are silently dropped.

Decomposition:
- Package ppi_pkg contains:
  - State typedef {IDLE, CAPTURE, FULL, READ}.
  - Port C bit-position constants: PC_INTR_A=3, PC_INTE_A=4, PC_IBF_A=5.
  - BSR field constants: BSR_SEL_BIT=7, BSR_IDX_MSB=3, BSR_IDX_LSB=1, BSR_VAL_BIT=0.
- Sub-module ppi_edge_sync: parameterized N-stage synchronizer with rise/fall pulse outputs.
  - Instantiated for STB_N with N=SYNC_STAGES.
  - Instantiated for RD_N with N=1.

Test Plan:
- Reset values: assert RESET_N=0 mid-CAPTURE -> DATA_OUT=0, IBF=0, INTR=0, INTE=0 immediately, without waiting for a clock.
- Basic handshake:
  - Stimulus: BSR word 0x09 (bit4 set), then PA_IN=0xA5 with STB_N low for 4 cycles, then high.
  - Response: IBF=1 at cycle 3 after the fall; DATA_OUT=0xA5; INTR=1 three cycles after the rise.
  - Stimulus: RD_N pulse.
  - Response: INTR=0 two cycles after the RD fall; IBF=0 two cycles after the RD rise.
- INTE disabled:
  - Stimulus: BSR word 0x08, then a strobe of 0x3C.
  - Response: IBF=1, DATA_OUT=0x3C, INTR stays 0.
  - Stimulus: BSR word 0x09 while in FULL.
  - Response: INTR=1 next cycle.
- BSR filtering: words 0x89 and 0x0B with INTE=0 -> INTE remains 0.
- Overrun:
  - Stimulus: in FULL with DATA_OUT=0x11, strobe PA_IN=0x22.
  - Response: DATA_OUT stays 0x11 and state stays FULL; OVERRUN=1 when PPI_OVERRUN_FLAG_EN is defined, cleared after the read.
- ENABLE drop: ENABLE=0 in FULL -> IBF=0, INTR=0, DATA_OUT held, INTE unchanged; a strobe while disabled is ignored.
